external_memory_burst: RTL and testbench
========================================

Name: external_memory_burst

Overview:
- Parametrised 1R1W behavioural model of the off-chip RAM with independent read and write burst channels.
- Each channel has a valid/ready request handshake.
- Read data returns with a fixed, configurable latency.
- Sits at the top level between the DMA/load-store engines and the accelerator datapath; replaces the single-beat model for burst traffic and latency sensitivity.

Parameters:
DATA_W, `WID_EXT_RAM, data word width
ADDR_W, `ADDR_EXT_RAM, word address width; depth = 2**ADDR_W
LEN_W, 8, burst length field width; beats = len+1
RD_LAT, 2, cycles from read beat issue to rd_data_valid (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
rd_req_valid  in  1  read burst request
rd_req_ready  out  1  read channel idle, request accepted when valid&ready
rd_req_addr  in  ADDR_W  read start word address
rd_req_len  in  LEN_W  read beats minus one
rd_data_valid  out  1  read beat valid (no backpressure)
rd_data  out  DATA_W  read beat data
rd_data_last  out  1  final beat of burst, qualified by rd_data_valid
wr_req_valid  in  1  write burst request
wr_req_ready  out  1  write channel idle
wr_req_addr  in  ADDR_W  write start word address
wr_req_len  in  LEN_W  write beats minus one
wr_data_valid  in  1  write beat valid
wr_data_ready  out  1  high while in WR_DATA
wr_data  in  DATA_W  write beat data
wr_done  out  1  one-cycle pulse after the last beat is written

Behaviour:
- Reset (rst_n=0 at posedge):
  - Both FSMs go to IDLE; burst counters and read pipeline valids clear.
  - Outputs: rd_req_ready=1 and wr_req_ready=1 on the cycle after reset deasserts; rd_data_valid=0, rd_data=0, rd_data_last=0, wr_data_ready=0, wr_done=0.
  - Memory contents are NOT reset.
- Read FSM, IDLE -> RD_BURST:
  - On rd_req_valid&rd_req_ready, latch addr and len into the address register and beat counter; rd_req_ready=0 from the next cycle.
- Read FSM, RD_BURST:
  - Issue one beat per cycle: read mem[addr], addr<=addr+1 mod 2**ADDR_W, count down.
  - On the last issue, return to IDLE; rd_req_ready=1 the following cycle.
  - A back-to-back request yields exactly one idle issue cycle between bursts.
- Read data path:
  - A beat issued at cycle t appears on rd_data with rd_data_valid=1 at cycle t+RD_LAT.
  - rd_data_last travels with the final beat.
  - rd_data holds its last value when rd_data_valid=0.
- Write FSM, IDLE -> WR_DATA:
  - On wr_req_valid&wr_req_ready, latch addr and len.
- Write FSM, WR_DATA:
  - wr_data_ready=1. Each cycle with wr_data_valid: mem[addr]<=wr_data, addr increments with wrap, count decrements.
  - Cycles without wr_data_valid stall with no write.
  - After the last beat: wr_done=1 for one cycle, FSM returns to IDLE, wr_req_ready=1 next cycle.
- Simultaneous read issue and write to the same address in one cycle: the read returns the OLD data (read-before-write).
- Address wrap: a burst crossing the top address continues at 0. No error is raised.
- len=0 is a single-beat burst. Maximum burst is 2**LEN_W beats.
- Reset mid-burst:
  - Remaining beats are abandoned; in-flight read beats are dropped (rd_data_valid=0); no wr_done.
  - Writes already performed persist.
- Read and write channels are fully independent and may run concurrently.

Decomposition:
- header.vh holds:
  - `WID_EXT_RAM and `ADDR_EXT_RAM defaults
  - read/write FSM state encodings as `define constants (IDLE, RD_BURST, WR_DATA)
- Sub-module ext_ram_array: parametrised 1R1W synchronous array with read-before-write.
  - Read port: raddr, re, rdata (1-cycle).
  - Write port: waddr, we, wdata.
  - The top adds RD_LAT-1 pipeline stages on data/valid/last.

Test Plan:
- Write 4 beats 0xA0..0xA3 at addr 0x10 (len=3), then read addr 0x10 len=3 -> wr_done pulses once; rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting RD_LAT cycles after first issue; rd_data_last only on 0xA3.
- Write len=2 at addr 2**ADDR_W-2 with data 1,2,3, then read back the same burst -> mem[top-1]=1, mem[top]=2, mem[0]=3; readback sequence matches.
- Write burst with wr_data_valid toggling 1,0,0,1,1 (len=2) -> exactly 3 writes at consecutive addresses; wr_data_ready stays 1 until the last beat; wr_done asserted the cycle after the third beat.
- mem[0x20]=0x55; in one cycle issue a read of 0x20 and write 0x77 to 0x20 -> read returns 0x55; a subsequent read returns 0x77.
- Assert rst_n=0 for one cycle during beat 2 of a len=7 read -> rd_data_valid=0 from the next cycle for all dropped beats; both req_ready=1 after reset; prior memory contents intact.
- Concurrent read (len=15) and write (len=15) to disjoint regions -> both complete with no lost beats; rd_req_ready reasserts exactly 1 cycle after the last issue.

Source files
------------

// File: rtl/external_memory_burst_pkg.sv
//==============================================================================
// Module      : external_memory_burst_pkg
// Description : Shared definitions for the burst external-RAM model: default
//               word/address widths, FSM state encodings and the state enums
//               used by the read and write channel controllers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// Project-wide defaults for the off-chip RAM geometry. Guarded so an
// integrating build can override them before this file is read.
`ifndef WID_EXT_RAM
`define WID_EXT_RAM 32
`endif
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 8
`endif

// Channel FSM state encodings. Both channels share the IDLE code; the busy
// state of each channel is the single non-idle code.
`ifndef IDLE
`define IDLE 1'b0
`endif
`ifndef RD_BURST
`define RD_BURST 1'b1
`endif
`ifndef WR_DATA
`define WR_DATA 1'b1
`endif

package external_memory_burst_pkg;

    typedef enum logic [0:0] {
        RD_IDLE  = `IDLE,
        RD_BURST = `RD_BURST
    } rd_state_e;

    typedef enum logic [0:0] {
        WR_IDLE = `IDLE,
        WR_DATA = `WR_DATA
    } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/external_memory_burst_ext_ram_array.sv
//==============================================================================
// Module      : ext_ram_array
// Description : 1R1W synchronous storage array. A read and a write to the same
//               address in one cycle return the pre-write contents. Storage is
//               never reset; only the read data register is.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               raddr, re, rdata    - read port, data valid one cycle after re
//               waddr, we, wdata    - write port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ext_ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents survive reset so writes completed before a reset persist.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of r_mem yields the old word on a same-cycle write.
    // The register only loads on re, so it holds between read beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/external_memory_burst.sv
//==============================================================================
// Module      : external_memory_burst
// Description : Behavioural off-chip RAM with independent read and write
//               burst channels, valid/ready request handshakes and a fixed
//               read latency of RD_LAT cycles from beat issue to data.
// Ports       : clk, rst_n                       - clock, sync active-low reset
//               rd_req_valid/ready/addr/len      - read burst request
//               rd_data_valid, rd_data, rd_data_last - read beat return
//               wr_req_valid/ready/addr/len      - write burst request
//               wr_data_valid/ready, wr_data     - write beat stream
//               wr_done                          - pulse after last write beat
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module external_memory_burst #(
    parameter int DATA_W = `WID_EXT_RAM,
    parameter int ADDR_W = `ADDR_EXT_RAM,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done
);

    import external_memory_burst_pkg::*;

    //--------------------------------------------------------------------------
    // Read channel controller
    //--------------------------------------------------------------------------
    rd_state_e         r_rd_state;
    rd_state_e         w_rd_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  w_rd_cnt_nxt;
    logic              w_rd_issue;
    logic              w_rd_issue_last;
    logic              w_rd_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_rd_addr  <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
        end
    end

    // The beat counter holds "beats remaining minus one", so the issue that
    // sees zero is the final one. Address arithmetic wraps naturally at the
    // ADDR_W boundary.
    always_comb begin
        w_rd_state_nxt  = r_rd_state;
        w_rd_addr_nxt   = r_rd_addr;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_rd_issue      = 1'b0;
        w_rd_issue_last = 1'b0;
        w_rd_req_ready  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_rd_req_ready = 1'b1;
                if (rd_req_valid) begin
                    w_rd_state_nxt = RD_BURST;
                    w_rd_addr_nxt  = rd_req_addr;
                    w_rd_cnt_nxt   = rd_req_len;
                end
            end
            RD_BURST: begin
                w_rd_issue    = 1'b1;
                w_rd_addr_nxt = r_rd_addr + 1'b1;
                w_rd_cnt_nxt  = r_rd_cnt - 1'b1;
                if (r_rd_cnt == '0) begin
                    w_rd_issue_last = 1'b1;
                    w_rd_state_nxt  = RD_IDLE;
                end
            end
            default: begin
                w_rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    assign rd_req_ready = w_rd_req_ready;

    //--------------------------------------------------------------------------
    // Write channel controller
    //--------------------------------------------------------------------------
    wr_state_e         r_wr_state;
    wr_state_e         w_wr_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [LEN_W-1:0]  r_wr_cnt;
    logic [LEN_W-1:0]  w_wr_cnt_nxt;
    logic              w_wr_we;
    logic              r_wr_done;
    logic              w_wr_done_nxt;
    logic              w_wr_req_ready;
    logic              w_wr_data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= WR_IDLE;
            r_wr_addr  <= '0;
            r_wr_cnt   <= '0;
            r_wr_done  <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wr_done  <= w_wr_done_nxt;
        end
    end

    // Beats only advance on wr_data_valid; idle cycles inside the burst stall
    // without touching the array.
    always_comb begin
        w_wr_state_nxt  = r_wr_state;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_wr_we         = 1'b0;
        w_wr_done_nxt   = 1'b0;
        w_wr_req_ready  = 1'b0;
        w_wr_data_ready = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_wr_req_ready = 1'b1;
                if (wr_req_valid) begin
                    w_wr_state_nxt = WR_DATA;
                    w_wr_addr_nxt  = wr_req_addr;
                    w_wr_cnt_nxt   = wr_req_len;
                end
            end
            WR_DATA: begin
                w_wr_data_ready = 1'b1;
                if (wr_data_valid) begin
                    w_wr_we       = 1'b1;
                    w_wr_addr_nxt = r_wr_addr + 1'b1;
                    w_wr_cnt_nxt  = r_wr_cnt - 1'b1;
                    if (r_wr_cnt == '0) begin
                        w_wr_state_nxt = WR_IDLE;
                        w_wr_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_wr_state_nxt = WR_IDLE;
            end
        endcase
    end

    assign wr_req_ready  = w_wr_req_ready;
    assign wr_data_ready = w_wr_data_ready;
    assign wr_done       = r_wr_done;

    //--------------------------------------------------------------------------
    // Storage array (first read-latency stage lives inside it)
    //--------------------------------------------------------------------------
    logic [DATA_W-1:0] w_s0_data;
    logic              r_s0_valid;
    logic              r_s0_last;

    ext_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (r_rd_addr),
        .re    (w_rd_issue),
        .rdata (w_s0_data),
        .waddr (r_wr_addr),
        .we    (w_wr_we),
        .wdata (wr_data)
    );

    // Valid/last sidebands aligned with the array's registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            r_s0_valid <= w_rd_issue;
            r_s0_last  <= w_rd_issue_last;
        end
    end

    //--------------------------------------------------------------------------
    // Remaining RD_LAT-1 read-latency stages. Data only moves with a valid
    // beat so rd_data holds its last value between bursts; last is cleared
    // alongside valid so it never appears without a beat.
    //--------------------------------------------------------------------------
    generate
        if (RD_LAT <= 1) begin : g_lat_direct
            assign rd_data_valid = r_s0_valid;
            assign rd_data       = w_s0_data;
            assign rd_data_last  = r_s0_last;
        end else begin : g_lat_pipe
            logic [RD_LAT-2:0] r_pipe_valid;
            logic [RD_LAT-2:0] r_pipe_last;
            logic [DATA_W-1:0] r_pipe_data [RD_LAT-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pipe_valid <= '0;
                    r_pipe_last  <= '0;
                    for (int k = 0; k < RD_LAT - 1; k++) begin
                        r_pipe_data[k] <= '0;
                    end
                end else begin
                    r_pipe_valid[0] <= r_s0_valid;
                    r_pipe_last[0]  <= r_s0_valid & r_s0_last;
                    if (r_s0_valid) begin
                        r_pipe_data[0] <= w_s0_data;
                    end
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        r_pipe_valid[k] <= r_pipe_valid[k-1];
                        r_pipe_last[k]  <= r_pipe_valid[k-1] & r_pipe_last[k-1];
                        if (r_pipe_valid[k-1]) begin
                            r_pipe_data[k] <= r_pipe_data[k-1];
                        end
                    end
                end
            end

            assign rd_data_valid = r_pipe_valid[RD_LAT-2];
            assign rd_data       = r_pipe_data[RD_LAT-2];
            assign rd_data_last  = r_pipe_last[RD_LAT-2];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_external_memory_burst.sv
//==============================================================================
// Module      : tb_external_memory_burst
// Description : Directed self-checking bench for external_memory_burst with
//               DATA_W=32, ADDR_W=8, LEN_W=8, RD_LAT=2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_external_memory_burst;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_req_valid = 1'b0;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr = '0;
    logic [LEN_W-1:0]  rd_req_len = '0;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              wr_req_valid = 1'b0;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr = '0;
    logic [LEN_W-1:0]  wr_req_len = '0;
    logic              wr_data_valid = 1'b0;
    logic              wr_data_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] rd_q_data [$];
    logic              rd_q_last [$];
    int                rd_q_cyc  [$];
    int                wr_done_q [$];

    external_memory_burst #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_len    (rd_req_len),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .rd_data_last  (rd_data_last),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_len    (wr_req_len),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .wr_done       (wr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe returned read beats and write-done pulses mid-cycle.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            rd_q_data.push_back(rd_data);
            rd_q_last.push_back(rd_data_last);
            rd_q_cyc.push_back(cyc);
        end
        if (wr_done === 1'b1) wr_done_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers (no checking beyond handshake timeouts)
    //--------------------------------------------------------------------------
    task automatic clear_queues();
        rd_q_data.delete();
        rd_q_last.delete();
        rd_q_cyc.delete();
        wr_done_q.delete();
    endtask

    // Returns h = cycle in which the request handshake completes; returns
    // at the start of cycle h+1 (the first issue cycle).
    task automatic rd_request(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                              output int h);
        int n;
        n = 0;
        @(posedge clk); #1;
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        rd_req_len   = len;
        @(negedge clk);
        while (rd_req_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (rd_req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rd_req_timeout ready=%b required=1", rd_req_ready);
        end
        h = cyc;
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic wr_request(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                              output int h);
        int n;
        n = 0;
        @(posedge clk); #1;
        wr_req_valid = 1'b1;
        wr_req_addr  = addr;
        wr_req_len   = len;
        @(negedge clk);
        while (wr_req_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (wr_req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wr_req_timeout ready=%b required=1", wr_req_ready);
        end
        h = cyc;
        @(posedge clk); #1;
        wr_req_valid = 1'b0;
    endtask

    // Burst write of base, base+1, ... with every beat valid.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                            input logic [DATA_W-1:0] base, output int h);
        wr_request(addr, len, h);
        for (int i = 0; i <= int'(len); i++) begin
            wr_data_valid = 1'b1;
            wr_data       = base + DATA_W'(i);
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                           output int h);
        rd_request(addr, len, h);
        repeat (int'(len) + RD_LAT + 3) @(posedge clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready rd=%b wr=%b required=1/1", rd_req_ready, wr_req_ready);
        end
        checks++;
        if (rd_data_valid !== 1'b0 || rd_data_last !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_outputs valid=%b last=%b data=%h required=0/0/0",
                     rd_data_valid, rd_data_last, rd_data);
        end
        checks++;
        if (wr_data_ready !== 1'b0 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_outputs data_ready=%b done=%b required=0/0", wr_data_ready, wr_done);
        end
    endtask

    task automatic test_basic_burst();
        int h;
        @(posedge clk); #1;
        clear_queues();
        do_write(8'h10, 8'd3, 32'hA0, h);
        checks++;
        if (wr_done_q.size() != 1 || wr_done_q[0] != h + 5) begin
            errors++;
            $display("FAIL basic_wr_done pulses=%0d first_cyc=%0d required=1 at %0d",
                     wr_done_q.size(), (wr_done_q.size() > 0) ? wr_done_q[0] : -1, h + 5);
        end
        clear_queues();
        do_read(8'h10, 8'd3, h);
        checks++;
        if (rd_q_data.size() != 4) begin
            errors++;
            $display("FAIL basic_rd_count got=%0d required=4", rd_q_data.size());
        end
        for (int i = 0; i < 4 && i < rd_q_data.size(); i++) begin
            checks++;
            if (rd_q_data[i] !== 32'hA0 + 32'(i) || rd_q_cyc[i] != h + 1 + RD_LAT + i ||
                rd_q_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_rd_beat%0d data=%h cyc=%0d last=%b required=%h/%0d/%b", i,
                         rd_q_data[i], rd_q_cyc[i], rd_q_last[i], 32'hA0 + 32'(i),
                         h + 1 + RD_LAT + i, (i == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b0 || rd_data !== 32'hA3) begin
            errors++;
            $display("FAIL basic_rd_hold valid=%b data=%h required=0/a3", rd_data_valid, rd_data);
        end
    endtask

    task automatic test_wrap();
        int h;
        logic [DATA_W-1:0] exp_single [2];
        logic [ADDR_W-1:0] single_addr [2];
        exp_single[0]  = 32'd2;
        exp_single[1]  = 32'd3;
        single_addr[0] = 8'hFF;
        single_addr[1] = 8'h00;
        @(posedge clk); #1;
        do_write(8'hFE, 8'd2, 32'd1, h);
        clear_queues();
        do_read(8'hFE, 8'd2, h);
        checks++;
        if (rd_q_data.size() != 3) begin
            errors++;
            $display("FAIL wrap_rd_count got=%0d required=3", rd_q_data.size());
        end
        for (int i = 0; i < 3 && i < rd_q_data.size(); i++) begin
            checks++;
            if (rd_q_data[i] !== 32'(i + 1) || rd_q_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL wrap_rd_beat%0d data=%h last=%b required=%h/%b", i,
                         rd_q_data[i], rd_q_last[i], 32'(i + 1), (i == 2));
            end
        end
        // Single-beat (len=0) reads of the top address and address 0.
        for (int j = 0; j < 2; j++) begin
            clear_queues();
            do_read(single_addr[j], 8'd0, h);
            checks++;
            if (rd_q_data.size() != 1 || rd_q_data[0] !== exp_single[j] || rd_q_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_single_%h count=%0d data=%h required=1/%h", single_addr[j],
                         rd_q_data.size(), (rd_q_data.size() > 0) ? rd_q_data[0] : 32'hx, exp_single[j]);
            end
        end
    endtask

    task automatic test_stall();
        int h;
        logic       pat_v [5];
        logic [7:0] pat_d [5];
        pat_v[0] = 1'b1; pat_v[1] = 1'b0; pat_v[2] = 1'b0; pat_v[3] = 1'b1; pat_v[4] = 1'b1;
        pat_d[0] = 8'h31; pat_d[1] = 8'hDE; pat_d[2] = 8'hAD; pat_d[3] = 8'h32; pat_d[4] = 8'h33;
        @(posedge clk); #1;
        do_write(8'h30, 8'd3, 32'hE0, h);
        clear_queues();
        wr_request(8'h30, 8'd2, h);
        for (int i = 0; i < 5; i++) begin
            wr_data_valid = pat_v[i];
            wr_data       = {24'h0, pat_d[i]};
            @(negedge clk);
            checks++;
            if (wr_data_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_data_ready cyc=%0d got=%b required=1", cyc, wr_data_ready);
            end
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_done !== 1'b1 || wr_data_ready !== 1'b0 || wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_done done=%b data_ready=%b req_ready=%b required=1/0/1",
                     wr_done, wr_data_ready, wr_req_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_done_q.size() != 1 || wr_done_q[0] != h + 6) begin
            errors++;
            $display("FAIL stall_done_pulse count=%0d required=1 at %0d", wr_done_q.size(), h + 6);
        end
        clear_queues();
        do_read(8'h30, 8'd3, h);
        checks++;
        if (rd_q_data.size() != 4 || rd_q_data[0] !== 32'h31 || rd_q_data[1] !== 32'h32 ||
            rd_q_data[2] !== 32'h33 || rd_q_data[3] !== 32'hE3) begin
            errors++;
            $display("FAIL stall_readback count=%0d d0=%h d3=%h required=4 31,32,33,e3",
                     rd_q_data.size(), (rd_q_data.size() > 0) ? rd_q_data[0] : 32'hx,
                     (rd_q_data.size() > 3) ? rd_q_data[3] : 32'hx);
        end
    endtask

    task automatic test_read_before_write();
        int h;
        @(posedge clk); #1;
        do_write(8'h20, 8'd0, 32'h55, h);
        clear_queues();
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'h20;
        rd_req_len   = 8'd0;
        wr_req_valid = 1'b1;
        wr_req_addr  = 8'h20;
        wr_req_len   = 8'd0;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rbw_ready rd=%b wr=%b required=1/1", rd_req_ready, wr_req_ready);
        end
        h = cyc;
        @(posedge clk); #1;
        rd_req_valid  = 1'b0;
        wr_req_valid  = 1'b0;
        wr_data_valid = 1'b1;
        wr_data       = 32'h77;
        @(posedge clk); #1;
        wr_data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rd_q_data.size() != 1 || rd_q_data[0] !== 32'h55 || rd_q_cyc[0] != h + 1 + RD_LAT) begin
            errors++;
            $display("FAIL rbw_old_data count=%0d data=%h required=1 55 at %0d", rd_q_data.size(),
                     (rd_q_data.size() > 0) ? rd_q_data[0] : 32'hx, h + 1 + RD_LAT);
        end
        clear_queues();
        do_read(8'h20, 8'd0, h);
        checks++;
        if (rd_q_data.size() != 1 || rd_q_data[0] !== 32'h77) begin
            errors++;
            $display("FAIL rbw_new_data count=%0d data=%h required=1 77", rd_q_data.size(),
                     (rd_q_data.size() > 0) ? rd_q_data[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_burst();
        int h;
        @(posedge clk); #1;
        do_write(8'h40, 8'd7, 32'h40, h);
        rd_request(8'h40, 8'd7, h);
        @(posedge clk); #1;
        clear_queues();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b0 || rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state valid=%b rd_ready=%b wr_ready=%b required=0/1/1",
                     rd_data_valid, rd_req_ready, wr_req_ready);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (rd_q_data.size() != 0) begin
            errors++;
            $display("FAIL midrst_dropped beats_seen=%0d required=0", rd_q_data.size());
        end
        clear_queues();
        do_read(8'h40, 8'd7, h);
        checks++;
        if (rd_q_data.size() != 8) begin
            errors++;
            $display("FAIL midrst_readback_count got=%0d required=8", rd_q_data.size());
        end
        for (int i = 0; i < 8 && i < rd_q_data.size(); i++) begin
            checks++;
            if (rd_q_data[i] !== 32'h40 + 32'(i)) begin
                errors++;
                $display("FAIL midrst_readback%0d data=%h required=%h", i, rd_q_data[i], 32'h40 + 32'(i));
            end
        end
    endtask

    task automatic test_concurrent();
        int h;
        @(posedge clk); #1;
        do_write(8'hC0, 8'd15, 32'h2000, h);
        clear_queues();
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'hC0;
        rd_req_len   = 8'd15;
        wr_req_valid = 1'b1;
        wr_req_addr  = 8'h80;
        wr_req_len   = 8'd15;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL conc_ready rd=%b wr=%b required=1/1", rd_req_ready, wr_req_ready);
        end
        h = cyc;
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data_valid = 1'b1;
            wr_data       = 32'h1000 + 32'(i);
            @(negedge clk);
            checks++;
            if (rd_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL conc_rd_busy cyc=%0d ready=%b required=0", cyc, rd_req_ready);
            end
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b1 || wr_done !== 1'b1) begin
            errors++;
            $display("FAIL conc_end rd_ready=%b wr_done=%b required=1/1", rd_req_ready, wr_done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rd_q_data.size() != 16) begin
            errors++;
            $display("FAIL conc_rd_count got=%0d required=16", rd_q_data.size());
        end
        for (int i = 0; i < 16 && i < rd_q_data.size(); i++) begin
            checks++;
            if (rd_q_data[i] !== 32'h2000 + 32'(i) || rd_q_last[i] !== (i == 15) ||
                rd_q_cyc[i] != h + 1 + RD_LAT + i) begin
                errors++;
                $display("FAIL conc_rd_beat%0d data=%h last=%b cyc=%0d required=%h/%b/%0d", i,
                         rd_q_data[i], rd_q_last[i], rd_q_cyc[i], 32'h2000 + 32'(i), (i == 15),
                         h + 1 + RD_LAT + i);
            end
        end
        clear_queues();
        do_read(8'h80, 8'd15, h);
        checks++;
        if (rd_q_data.size() != 16) begin
            errors++;
            $display("FAIL conc_wr_count got=%0d required=16", rd_q_data.size());
        end
        for (int i = 0; i < 16 && i < rd_q_data.size(); i++) begin
            checks++;
            if (rd_q_data[i] !== 32'h1000 + 32'(i)) begin
                errors++;
                $display("FAIL conc_wr_beat%0d data=%h required=%h", i, rd_q_data[i], 32'h1000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_wrap();
        test_stall();
        test_read_before_write();
        test_reset_mid_burst();
        test_concurrent();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
